// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants and tx FSM state encoding
package uart_pkg;
  localparam int CLKS_PER_BIT_DEF = 10416;
  localparam int FRAME_BITS = 8;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: single-clock FIFO with combinational head byte
module uart_fifo #(
  parameter int DEPTH = 16,
  parameter int W = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  count
);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  assign dout = mem[rptr];
  always_ff @(posedge clk)
    if (!nrst) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop) rptr <= rptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wptr] <= din;
endmodule

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: 8N1 UART transmitter fed by a byte FIFO
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         nrst,
  input  logic [7:0]                   din,
  input  logic                         din_valid,
  output logic                         din_ready,
  output logic                         tx,
  output logic                         busy,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);
  localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = $clog2(FRAME_BITS);
  tx_state_t state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [FRAME_BITS-1:0] shift, head;
  logic en, full, empty, tc, pop;
  assign tc = cnt == CW'(CLKS_PER_BIT - 1);
  assign pop = ~empty & (state == IDLE | (state == STOP & tc));
  assign din_ready = en & ~full;
  assign busy = state != IDLE | ~empty;
  uart_fifo #(.DEPTH(FIFO_DEPTH), .W(FRAME_BITS)) u_fifo (
    .clk,
    .nrst,
    .push(din_valid & din_ready),
    .pop,
    .din,
    .dout(head),
    .full,
    .empty,
    .count(fifo_count)
  );
  always_ff @(posedge clk)
    if (!nrst) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      shift <= '0;
      tx <= 1'b1;
      en <= 1'b0;
    end else begin
      en <= 1'b1;
      tx <= state == START ? 1'b0 : state == DATA ? shift[0] : 1'b1;
      cnt <= (state == IDLE || tc) ? '0 : cnt + 1'b1;
      if (pop) begin
        shift <= head;
        state <= START;
      end else if (tc && state != IDLE) begin
        if (state == START) begin
          state <= DATA;
          idx <= '0;
        end else if (state == DATA) begin
          shift <= shift >> 1;
          idx <= idx + 1'b1;
          if (idx == IW'(FRAME_BITS - 1)) state <= STOP;
        end else state <= IDLE;
      end
    end
endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb_uart_tx_buffered: scoreboard bench decoding tx frames against pushed bytes
module tb_uart_tx_buffered;
  localparam int CPB = 16;
  localparam int DEPTH = 16;
  localparam int FRAME = 10 * CPB;
  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic din_valid = 1'b0;
  logic [7:0] din = '0;
  logic din_ready, tx, busy;
  logic [4:0] fifo_count;
  int n_cmp = 0;
  int n_bad = 0;
  typedef struct {
    logic [7:0] d;
    bit ok;
    longint t;
  } rec_t;
  rec_t rx_q[$];
  logic [7:0] exp_q[$];
  bit mon_en = 1'b1;
  longint last_acc;
  logic [9:0] mbits;
  bit mok;
  rec_t mrec;
  always #5 clk = ~clk;
  uart_tx_buffered #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk),
    .nrst(nrst),
    .din(din),
    .din_valid(din_valid),
    .din_ready(din_ready),
    .tx(tx),
    .busy(busy),
    .fifo_count(fifo_count)
  );
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && tx === 1'b0) begin
        mok = 1'b1;
        mrec.t = $time - 5;
        for (int i = 0; i < FRAME; i++) begin
          if (i > 0) @(negedge clk);
          if (i % CPB == 0) mbits[i/CPB] = tx;
          else if (tx !== mbits[i/CPB]) mok = 1'b0;
        end
        mrec.ok = mok && mbits[0] === 1'b0 && mbits[9] === 1'b1;
        mrec.d = mbits[8:1];
        rx_q.push_back(mrec);
      end
    end
  end
  task automatic push(input logic [7:0] b);
    @(negedge clk);
    din = b;
    din_valid = 1'b1;
    @(posedge clk);
    last_acc = $time;
    exp_q.push_back(b);
    #1 din_valid = 1'b0;
  endtask
  task automatic wait_frames(input int n, output bit ok);
    int k = 0;
    while (rx_q.size() < n && k < (n + 2) * FRAME) begin
      @(negedge clk);
      k++;
    end
    ok = rx_q.size() >= n;
  endtask
  task automatic test_reset;
    nrst = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL reset_tx: got %b expected 1", tx); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (din_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b expected 0", din_ready); end
    n_cmp++; if (fifo_count !== 5'd0) begin n_bad++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
    nrst = 1'b1;
    @(negedge clk);
    n_cmp++; if (din_ready !== 1'b1) begin n_bad++; $display("FAIL ready_after_reset: got %b expected 1", din_ready); end
    n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL idle_tx: got %b expected 1", tx); end
  endtask
  task automatic test_single;
    bit ok;
    rec_t r;
    logic [7:0] e;
    push(8'h45);
    @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy: got %b expected 1", busy); end
    n_cmp++; if (fifo_count !== 5'd1) begin n_bad++; $display("FAIL single_count: got %0d expected 1", fifo_count); end
    wait_frames(1, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++; $display("FAIL single_timeout: got %0d frames expected 1", rx_q.size());
      rx_q.delete(); exp_q.delete();
    end else begin
      r = rx_q.pop_front(); e = exp_q.pop_front();
      if (r.d !== e || !r.ok) begin n_bad++; $display("FAIL single_data: got %02h ok=%0d expected %02h", r.d, r.ok, e); end
      n_cmp++; if (r.t != last_acc + 20) begin n_bad++; $display("FAIL single_latency: got %0d ns expected %0d ns", r.t - last_acc, 20); end
    end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_busy_end: got %b expected 0", busy); end
  endtask
  task automatic test_idle_second;
    bit ok;
    rec_t r;
    logic [7:0] e;
    int lows = 0;
    repeat (20 * CPB) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    n_cmp++; if (lows != 0) begin n_bad++; $display("FAIL idle_line: got %0d low samples expected 0", lows); end
    push(8'hD6);
    wait_frames(1, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++; $display("FAIL second_timeout: got %0d frames expected 1", rx_q.size());
      rx_q.delete(); exp_q.delete();
    end else begin
      r = rx_q.pop_front(); e = exp_q.pop_front();
      if (r.d !== e || !r.ok) begin n_bad++; $display("FAIL second_data: got %02h ok=%0d expected %02h", r.d, r.ok, e); end
      n_cmp++; if (r.t != last_acc + 20) begin n_bad++; $display("FAIL second_latency: got %0d ns expected %0d ns", r.t - last_acc, 20); end
    end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL second_busy_end: got %b expected 0", busy); end
  endtask
  task automatic test_back_to_back;
    bit ok;
    rec_t r;
    logic [7:0] e;
    longint a0;
    push(8'h00);
    a0 = last_acc;
    push(8'hFF);
    push(8'hA5);
    @(negedge clk);
    n_cmp++; if (fifo_count !== 5'd2) begin n_bad++; $display("FAIL b2b_count: got %0d expected 2", fifo_count); end
    wait_frames(3, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++; $display("FAIL b2b_timeout: got %0d frames expected 3", rx_q.size());
      rx_q.delete(); exp_q.delete();
    end else begin
      for (int i = 0; i < 3; i++) begin
        r = rx_q.pop_front(); e = exp_q.pop_front();
        n_cmp++; if (r.d !== e || !r.ok) begin n_bad++; $display("FAIL b2b_data%0d: got %02h ok=%0d expected %02h", i, r.d, r.ok, e); end
        n_cmp++; if (r.t != a0 + 20 + longint'(i) * FRAME * 10) begin n_bad++; $display("FAIL b2b_start%0d: got %0d ns expected %0d ns", i, r.t - a0, 20 + i * FRAME * 10); end
      end
    end
    repeat (4) @(negedge clk);
  endtask
  task automatic test_full;
    bit ok;
    rec_t r;
    logic [7:0] e;
    longint t0 = 0;
    int k = 0;
    int bad_ready = 0;
    for (int j = 0; j < 17; j++) begin
      @(negedge clk);
      if (din_ready !== 1'b1) bad_ready++;
      din = 8'(j + 1);
      din_valid = 1'b1;
      @(posedge clk);
      if (j == 0) t0 = $time;
      exp_q.push_back(8'(j + 1));
    end
    n_cmp++; if (bad_ready != 0) begin n_bad++; $display("FAIL full_fill_ready: got %0d stalls expected 0", bad_ready); end
    @(negedge clk);
    din = 8'h12;
    n_cmp++; if (din_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready: got %b expected 0", din_ready); end
    n_cmp++; if (fifo_count !== 5'd16) begin n_bad++; $display("FAIL full_count: got %0d expected 16", fifo_count); end
    while (din_ready !== 1'b1 && k < 2 * FRAME) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk);
    exp_q.push_back(8'h12);
    n_cmp++; if (($time - t0) / 10 != 162) begin n_bad++; $display("FAIL full_admit_edge: got %0d expected 162", ($time - t0) / 10); end
    #1 din_valid = 1'b0;
    wait_frames(18, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++; $display("FAIL full_timeout: got %0d frames expected 18", rx_q.size());
      rx_q.delete(); exp_q.delete();
    end else begin
      for (int i = 0; i < 18; i++) begin
        r = rx_q.pop_front(); e = exp_q.pop_front();
        n_cmp++; if (r.d !== e || !r.ok) begin n_bad++; $display("FAIL full_data%0d: got %02h ok=%0d expected %02h", i, r.d, r.ok, e); end
      end
    end
    repeat (4) @(negedge clk);
  endtask
  task automatic test_reset_mid;
    int lows = 0;
    int busies = 0;
    mon_en = 1'b0;
    push(8'h55);
    for (int j = 1; j <= 4; j++) push(8'(j));
    repeat (68) @(negedge clk);
    n_cmp++; if (tx !== 1'b0) begin n_bad++; $display("FAIL mid_bit3: got %b expected 0", tx); end
    n_cmp++; if (fifo_count !== 5'd4) begin n_bad++; $display("FAIL mid_count: got %0d expected 4", fifo_count); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL mid_busy: got %b expected 1", busy); end
    nrst = 1'b0;
    @(negedge clk);
    n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL abort_tx: got %b expected 1", tx); end
    n_cmp++; if (fifo_count !== 5'd0) begin n_bad++; $display("FAIL abort_count: got %0d expected 0", fifo_count); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b expected 0", busy); end
    n_cmp++; if (din_ready !== 1'b0) begin n_bad++; $display("FAIL abort_ready: got %b expected 0", din_ready); end
    nrst = 1'b1;
    exp_q.delete();
    repeat (3 * FRAME) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
      if (busy !== 1'b0) busies++;
    end
    n_cmp++; if (lows != 0) begin n_bad++; $display("FAIL abort_quiet_tx: got %0d low samples expected 0", lows); end
    n_cmp++; if (busies != 0) begin n_bad++; $display("FAIL abort_quiet_busy: got %0d busy samples expected 0", busies); end
    mon_en = 1'b1;
  endtask
  task automatic test_loopback;
    bit ok;
    rec_t r;
    logic [7:0] e;
    push(8'h45);
    push(8'hD6);
    wait_frames(2, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++; $display("FAIL loop_timeout: got %0d frames expected 2", rx_q.size());
      rx_q.delete(); exp_q.delete();
    end else begin
      for (int i = 0; i < 2; i++) begin
        r = rx_q.pop_front(); e = exp_q.pop_front();
        n_cmp++; if (r.d !== e || !r.ok) begin n_bad++; $display("FAIL loop_data%0d: got %02h ok=%0d expected %02h", i, r.d, r.ok, e); end
      end
    end
  endtask
  initial begin
    test_reset;
    test_single;
    test_idle_second;
    test_back_to_back;
    test_full;
    test_reset_mid;
    test_loopback;
    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
